rx_byte_fifo: RTL and testbench

RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

---
 rtl/rx_byte_fifo.sv | 97 +++++++++
 tb/tb_rx_byte_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rx_byte_fifo.sv
// Receive byte FIFO between the UART receiver and its consumer.
// First-word-fall-through head, sticky overrun flag and saturating drop counter.
module rx_byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  asy_reset,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic [7:0]            drop_count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;
  logic                  push;
  logic                  pop;
  logic                  discard;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    if (value == 8'd255) begin
      sat_inc = 8'd255;
    end else begin
      sat_inc = value + 8'd1;
    end
  endfunction

  assign wr_idx   = wr_ptr[AW-1:0];
  assign rd_idx   = rd_ptr[AW-1:0];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count    = wr_ptr - rd_ptr;
  assign rd_valid = ~empty;
  // A full FIFO still accepts a byte when the head leaves in the same edge.
  assign pop      = rd_valid & rd_ready;
  assign push     = data_valid & (~full | pop);
  assign discard  = data_valid & ~push;

  // Head byte, forced to zero while empty so stale contents never leak out.
  always_comb begin
    rd_data = {DATA_WIDTH{1'b0}};
    if (!empty) begin
      rd_data = mem[rd_idx];
    end else begin
      rd_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_based_on_prescale) begin
    if (push) begin
      mem[wr_idx] <= P_DATA;
    end
  end

  // Read and write pointers with the extra wrap bit.
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Overrun bookkeeping; a discard in the clearing cycle is counted afresh.
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      overrun    <= 1'b0;
      drop_count <= 8'd0;
    end else if (overrun_clr) begin
      overrun    <= discard;
      drop_count <= discard ? 8'd1 : 8'd0;
    end else if (discard) begin
      overrun    <= 1'b1;
      drop_count <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Bench for rx_byte_fifo: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_rx_byte_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          asy_reset;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overrun;
  logic          overrun_clr;
  logic [7:0]    drop_count;

  logic [DW-1:0] q[$];
  logic          m_ovr;
  int            m_drops;
  int            n_assert = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  rx_byte_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk_based_on_prescale(clk),
    .asy_reset(asy_reset),
    .P_DATA(P_DATA),
    .data_valid(data_valid),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .count(count),
    .overrun(overrun),
    .overrun_clr(overrun_clr),
    .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rd_valid", {31'd0, rd_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
    chk("rd_data", {24'd0, rd_data}, (q.size() != 0) ? {24'd0, q[0]} : 32'd0);
    chk("empty", {31'd0, empty}, (q.size() == 0) ? 32'd1 : 32'd0);
    chk("full", {31'd0, full}, (q.size() == DEPTH) ? 32'd1 : 32'd0);
    chk("count", {28'd0, count}, q.size());
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    chk("drop_count", {24'd0, drop_count}, m_drops);
  endtask

  // One clock: apply inputs, advance the model, check after the edge.
  task automatic cycle(input logic dv, input logic [DW-1:0] d, input logic rr, input logic clr);
    logic do_pop, do_push, disc;
    data_valid  = dv;
    P_DATA      = d;
    rd_ready    = rr;
    overrun_clr = clr;
    do_pop  = (q.size() > 0) && rr;
    do_push = dv && ((q.size() < DEPTH) || do_pop);
    disc    = dv && !do_push;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
    if (clr) begin
      m_ovr   = disc;
      m_drops = disc ? 1 : 0;
    end else if (disc) begin
      m_ovr = 1'b1;
      if (m_drops < 255) m_drops++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    @(negedge clk);
    data_valid  = 1'b0;
    rd_ready    = 1'b0;
    overrun_clr = 1'b0;
    asy_reset   = 1'b0;
    #1;
    q.delete();
    m_ovr   = 1'b0;
    m_drops = 0;
    check_all();
    @(negedge clk);
    asy_reset = 1'b1;
  endtask

  task automatic drain();
    while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    asy_reset   = 1'b0;
    data_valid  = 1'b0;
    rd_ready    = 1'b0;
    overrun_clr = 1'b0;
    P_DATA      = 8'h00;
    m_ovr       = 1'b0;
    m_drops     = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    asy_reset = 1'b1;

    // Single byte round trip
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("single_data", {24'd0, rd_data}, 32'hA5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill, overflow by one, drain in order
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h09, 1'b0, 1'b0);
    chk("ovf_drop", {24'd0, drop_count}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", {24'd0, rd_data}, i);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous push and pop while full
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("full_pp_count", {28'd0, count}, 32'd8);
    chk("full_pp_ovr", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("last_is_55", {24'd0, rd_data}, 32'h55);

    // Saturation of the drop counter, then clear colliding with a discard
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("drop_sat", {24'd0, drop_count}, 32'd255);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("clr_collide_drop", {24'd0, drop_count}, 32'd1);
    chk("clr_collide_ovr", {31'd0, overrun}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    drain();

    // Streaming: pointers wrap twice, occupancy stays at one
    cycle(1'b1, 8'h80, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset flushes a partially filled FIFO
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    mid_reset();
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_reset_head", {24'd0, rd_data}, 32'h3C);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 40) == 0));
      if ($urandom_range(0, 150) == 0) mid_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
